// File: rtl/multi_arbiter.sv
// Round-robin front end sharing one start/done compute unit between two
// valid/ready requesters, with a per-transaction watchdog.
module multi_arbiter #(
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_inp,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_inp,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_out,
  output logic         rsp_err,
  output logic         unit_start,
  output logic [W-1:0] unit_inp,
  input  logic         unit_done,
  input  logic [W-1:0] unit_out,
  output logic         stray_done
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  state_t        state, state_nxt;
  logic          prio, owner;
  logic [CW-1:0] cnt;
  rsp_t          rsp_q;
  logic          stray_q;

  logic grant0, grant1, accept, timeout, in_resp, rsp_hs;

  // prio names the favoured requester; the other wins only when prio is idle
  assign grant0  = req0_valid && (!prio || !req1_valid);
  assign grant1  = req1_valid && ( prio || !req0_valid);
  assign accept  = reset && (state == IDLE) && (req0_valid || req1_valid);
  assign timeout = (cnt == CW'(TIMEOUT - 1));
  assign in_resp = reset && (state == RESP);
  assign rsp_hs  = in_resp && (owner ? rsp1_ready : rsp0_ready);

  assign req0_ready = accept && grant0;
  assign req1_ready = accept && grant1;
  assign unit_start = accept;
  assign unit_inp   = accept ? (grant1 ? req1_inp : req0_inp) : '0;

  assign rsp0_valid = in_resp && !owner;
  assign rsp1_valid = in_resp &&  owner;
  assign rsp_out    = in_resp ? rsp_q.data : '0;
  assign rsp_err    = in_resp && rsp_q.err;
  assign stray_done = stray_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (unit_done || timeout) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      prio    <= 1'b0;
      owner   <= 1'b0;
      cnt     <= '0;
      rsp_q   <= '0;
      stray_q <= 1'b0;
    end else begin
      state <= state_nxt;
      // a done with nothing in flight (including one after an abort) is dropped
      if (unit_done && state != BUSY) stray_q <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          owner <= grant1;
          cnt   <= '0;
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          if (unit_done)    rsp_q <= '{data: unit_out, err: 1'b0};
          else if (timeout) rsp_q <= '{data: '0,       err: 1'b1};
        end
        RESP: if (rsp_hs) prio <= ~owner;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multi_arbiter.md
Name: multi_arbiter

Overview:
- Shares one multi-cycle compute unit between two requesters. The unit uses a start/done protocol on a W-bit datapath, for example a multi0 instance.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Arbitration is round-robin, one transaction in flight at a time.
- A watchdog aborts transactions whose done never arrives.
- Sits between client logic and the shared unit; the unit itself is instantiated outside this block.

Parameters:
W, 32, data width of request/response and unit datapath
TIMEOUT, 64, max cycles in BUSY awaiting unit_done before abort (>=2)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clock)
req0_valid  in  1  requester 0 has operand
req0_ready  out  1  requester 0 operand accepted this cycle
req0_inp  in  W  requester 0 operand
rsp0_valid  out  1  requester 0 result available
rsp0_ready  in  1  requester 0 takes result
req1_valid, req1_ready, req1_inp, rsp1_valid, rsp1_ready  same as requester 0, for requester 1
rsp_out  out  W  result, meaningful when either rsp*_valid
rsp_err  out  1  result aborted by timeout, qualified by rsp*_valid
unit_start  out  1  one-cycle start pulse to shared unit
unit_inp  out  W  operand to unit, valid when unit_start
unit_done  in  1  unit result pulse
unit_out  in  W  unit result, valid when unit_done
stray_done  out  1  sticky: unit_done seen outside BUSY

Behaviour:
- Reset (reset==0 at posedge): state IDLE, prio=0, rsp regs cleared, cycle counter 0, stray_done 0.
- Outputs while in reset state: req*_ready 0, rsp*_valid 0, unit_start 0, rsp_out 0, rsp_err 0.
- FSM states: IDLE, BUSY, RESP. The grant register (owner) records which requester is served.
- IDLE:
  - Grant to req{prio} if it is valid, else to the other requester if it is valid.
  - req{g}_ready=1 combinationally for the granted requester only.
  - The accept cycle drives unit_start=1 and unit_inp=req{g}_inp (combinational, same cycle).
  - Then owner<=g, counter<=0, next state BUSY.
  - With no valid request, stay in IDLE, all outputs 0.
- BUSY:
  - req*_ready=0 and unit_start=0; counter increments each cycle.
  - On unit_done: rsp_out<=unit_out, rsp_err<=0, next state RESP.
  - If the counter reaches TIMEOUT-1 without unit_done: rsp_out<=0, rsp_err<=1, next state RESP.
  - unit_done on the timeout cycle wins (normal result).
- RESP:
  - rsp{owner}_valid=1; rsp_out/rsp_err are held stable.
  - On rsp{owner}_ready=1: next state IDLE, prio<=~owner.
  - A new request is never accepted in the same cycle a response completes; minimum one IDLE cycle.
- Latency:
  - Accept at cycle T, unit_done at T+L → rsp valid from T+L+1.
  - Back-to-back throughput is one transaction per L+2 cycles with rsp_ready held high.
- Request handshake: req_inp is sampled only on the accept cycle; requesters may change it otherwise. req*_valid is not required to stay high.
- stray_done:
  - Set on unit_done while in IDLE or RESP, including a late done after a timeout abort.
  - Cleared only by reset; the stray data is discarded.
- Reset mid-operation drops the in-flight transaction and returns to IDLE; no response is issued.
- Simultaneous req0/req1 in IDLE: prio decides. After serving requester k, prio favours the other requester.

Test Plan:
- Single request: req0_inp=0x1234, unit_done 3 cycles after start with unit_out=0x5678 → one unit_start pulse with unit_inp=0x1234; rsp0_valid next cycle, rsp_out=0x5678, rsp_err=0; rsp1_valid never set.
- Contention: req0 and req1 held valid continuously, unit L=2 → grants alternate 0,1,0,1; each gap between unit_start pulses is 4 cycles.
- Backpressure: rsp1_ready low 5 cycles → rsp1_valid and rsp_out stable all 5 cycles; req0 not accepted until one cycle after rsp1 handshake.
- Timeout with TIMEOUT=8: unit_done withheld → rsp_err=1, rsp_out=0 exactly 8 cycles after entering BUSY; a later unit_done sets stray_done=1.
- Reset mid-BUSY: reset=0 for one cycle, 2 cycles after start → IDLE, no rsp*_valid, prio=0, stray_done=0; next req1 is served normally.
- Done on timeout cycle: TIMEOUT=4, unit_done at the 4th BUSY cycle with unit_out=0xAA → rsp_err=0, rsp_out=0xAA.
